// File: rtl/queue_ctrl_5x79_if.sv
// Bundle of the enqueue/dequeue handshake and the ram_5x79 port signals.
// master = queue controller view, slave = producer/consumer/memory view.
interface queue_ctrl_5x79_if #(
  parameter int WIDTH = 79
);
  logic             io_enq_valid;
  logic             io_enq_ready;
  logic [WIDTH-1:0] io_enq_bits;
  logic             io_deq_valid;
  logic             io_deq_ready;
  logic [WIDTH-1:0] io_deq_bits;
  logic [2:0]       io_count;
  logic [2:0]       mem_W0_addr;
  logic             mem_W0_en;
  logic [WIDTH-1:0] mem_W0_data;
  logic [2:0]       mem_R0_addr;
  logic             mem_R0_en;
  logic [WIDTH-1:0] mem_R0_data;

  modport master (
    input  io_enq_valid, io_enq_bits, io_deq_ready, mem_R0_data,
    output io_enq_ready, io_deq_valid, io_deq_bits, io_count,
           mem_W0_addr, mem_W0_en, mem_W0_data, mem_R0_addr, mem_R0_en
  );

  modport slave (
    output io_enq_valid, io_enq_bits, io_deq_ready, mem_R0_data,
    input  io_enq_ready, io_deq_valid, io_deq_bits, io_count,
           mem_W0_addr, mem_W0_en, mem_W0_data, mem_R0_addr, mem_R0_en
  );
endinterface

// File: rtl/queue_ctrl_5x79.sv
// Ready/valid control for a 5-entry, 79-bit queue backed by ram_5x79.
// Pointers wrap modulo DEPTH; FLOW adds a zero-latency bypass when empty.
module queue_ctrl_5x79 #(
  parameter int WIDTH = 79,
  parameter int DEPTH = 5,
  parameter bit FLOW  = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  queue_ctrl_5x79_if.master q
);

  localparam logic [2:0] LAST_IDX = 3'(DEPTH - 1);
  localparam logic [3:0] DEPTH_4  = 4'(DEPTH);

  logic [2:0]       enq_ptr;
  logic [2:0]       deq_ptr;
  logic             maybe_full;

  logic             ptr_match;
  logic             empty;
  logic             full;
  logic             flow_empty;
  logic             enq_ready;
  logic             deq_valid;
  logic             enq_fire;
  logic             deq_fire;
  logic             do_enq;
  logic             do_deq;
  logic [WIDTH-1:0] deq_bits;
  logic [3:0]       diff_raw;
  logic [3:0]       count_wide;

  function automatic logic [2:0] next_ptr(input logic [2:0] p);
    logic [2:0] n;
    if (p == LAST_IDX) begin
      n = 3'd0;
    end else begin
      n = p + 3'd1;
    end
    return n;
  endfunction

  // Occupancy flags, handshakes, bypass select and memory strobes
  always_comb begin
    ptr_match  = (enq_ptr == deq_ptr);
    empty      = ptr_match & ~maybe_full;
    full       = ptr_match & maybe_full;
    flow_empty = FLOW & empty;
    enq_ready  = ~full & ~reset;
    deq_valid  = (~empty | (FLOW & q.io_enq_valid)) & ~reset;
    enq_fire   = q.io_enq_valid & enq_ready;
    deq_fire   = deq_valid & q.io_deq_ready;
    // A bypassed word goes straight to the consumer and never touches memory.
    do_enq     = enq_fire & ~(flow_empty & q.io_deq_ready);
    do_deq     = deq_fire & ~empty;
    if (flow_empty) begin
      deq_bits = q.io_enq_bits;
    end else begin
      deq_bits = q.mem_R0_data;
    end
  end

  // Occupancy: pointer distance modulo DEPTH, disambiguated by maybe_full
  always_comb begin
    diff_raw   = {1'b0, enq_ptr} + DEPTH_4 - {1'b0, deq_ptr};
    count_wide = 4'd0;
    if (ptr_match) begin
      if (maybe_full) begin
        count_wide = DEPTH_4;
      end else begin
        count_wide = 4'd0;
      end
    end else if (diff_raw >= DEPTH_4) begin
      count_wide = diff_raw - DEPTH_4;
    end else begin
      count_wide = diff_raw;
    end
  end

  // Pointer and wrap-flag state
  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr    <= 3'd0;
      deq_ptr    <= 3'd0;
      maybe_full <= 1'b0;
    end else begin
      if (do_enq) begin
        enq_ptr <= next_ptr(enq_ptr);
      end
      if (do_deq) begin
        deq_ptr <= next_ptr(deq_ptr);
      end
      if (do_enq != do_deq) begin
        maybe_full <= do_enq;
      end
    end
  end

  assign q.io_enq_ready = enq_ready;
  assign q.io_deq_valid = deq_valid;
  assign q.io_deq_bits  = deq_bits;
  assign q.io_count     = count_wide[2:0];
  assign q.mem_W0_addr  = enq_ptr;
  assign q.mem_W0_en    = do_enq;
  assign q.mem_W0_data  = q.io_enq_bits;
  assign q.mem_R0_addr  = deq_ptr;
  assign q.mem_R0_en    = 1'b1;

endmodule

// File: tb/tb_queue_ctrl_5x79.sv
// Scoreboard bench for queue_ctrl_5x79: one FLOW=0 and one FLOW=1 instance,
// each with a behavioural ram_5x79 (sync write, async read).
module tb_queue_ctrl_5x79;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  queue_ctrl_5x79_if #(.WIDTH(79)) ifa ();
  queue_ctrl_5x79_if #(.WIDTH(79)) ifb ();

  queue_ctrl_5x79 #(.WIDTH(79), .DEPTH(5), .FLOW(1'b0)) dut_a (
    .clock (clock),
    .reset (reset),
    .q     (ifa)
  );

  queue_ctrl_5x79 #(.WIDTH(79), .DEPTH(5), .FLOW(1'b1)) dut_b (
    .clock (clock),
    .reset (reset),
    .q     (ifb)
  );

  logic [78:0] mem_a [0:7];
  logic [78:0] mem_b [0:7];

  // Memory models standing in for ram_5x79
  always @(posedge clock) begin
    if (ifa.mem_W0_en) mem_a[ifa.mem_W0_addr] <= ifa.mem_W0_data;
    if (ifb.mem_W0_en) mem_b[ifb.mem_W0_addr] <= ifb.mem_W0_data;
  end
  assign ifa.mem_R0_data = mem_a[ifa.mem_R0_addr];
  assign ifb.mem_R0_data = mem_b[ifb.mem_R0_addr];

  int n_checks = 0;
  int n_fail   = 0;

  logic [78:0] sb_a [$];
  logic [78:0] sb_b [$];
  int cnt_a, cnt_b;
  logic [2:0] wptr_a, rptr_a, wptr_b, rptr_b;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] wrap_inc(input logic [2:0] p);
    return (p == 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

  function automatic logic [78:0] rand_word();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[78:0];
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1;
    ifa.io_enq_valid = 1'b1; ifa.io_enq_bits = '1; ifa.io_deq_ready = 1'b1;
    ifb.io_enq_valid = 1'b1; ifb.io_enq_bits = '1; ifb.io_deq_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_eq("rst_a_enq_ready", ifa.io_enq_ready, 1'b0);
      check_eq("rst_a_deq_valid", ifa.io_deq_valid, 1'b0);
      check_eq("rst_a_w_en",      ifa.mem_W0_en,    1'b0);
      check_eq("rst_b_deq_valid", ifb.io_deq_valid, 1'b0);
      check_eq("rst_b_w_en",      ifb.mem_W0_en,    1'b0);
      @(posedge clock); #1;
    end
    reset = 1'b0;
    ifa.io_enq_valid = 1'b0; ifa.io_deq_ready = 1'b0;
    ifb.io_enq_valid = 1'b0; ifb.io_deq_ready = 1'b0;
    cnt_a = 0; wptr_a = 3'd0; rptr_a = 3'd0; sb_a.delete();
    cnt_b = 0; wptr_b = 3'd0; rptr_b = 3'd0; sb_b.delete();
  endtask

  task automatic cycle_a(input logic ev, input logic [78:0] eb, input logic dr);
    logic exp_enq, exp_deq;
    logic [78:0] exp_bits;
    ifa.io_enq_valid = ev; ifa.io_enq_bits = eb; ifa.io_deq_ready = dr;
    @(negedge clock);
    exp_enq = ev && (cnt_a < 5);
    exp_deq = dr && (cnt_a > 0);
    check_eq("a_enq_ready", ifa.io_enq_ready, cnt_a < 5);
    check_eq("a_deq_valid", ifa.io_deq_valid, cnt_a > 0);
    check_eq("a_count",     ifa.io_count,     cnt_a);
    check_eq("a_w_en",      ifa.mem_W0_en,    exp_enq);
    check_eq("a_r_en",      ifa.mem_R0_en,    1'b1);
    check_eq("a_r_addr",    ifa.mem_R0_addr,  rptr_a);
    if (exp_enq) begin
      check_eq("a_w_addr", ifa.mem_W0_addr, wptr_a);
      check_eq("a_w_data", ifa.mem_W0_data, eb);
    end
    if (exp_deq) begin
      exp_bits = sb_a.pop_front();
      check_eq("a_deq_bits", ifa.io_deq_bits, exp_bits);
      rptr_a = wrap_inc(rptr_a);
    end
    if (exp_enq) begin
      sb_a.push_back(eb);
      wptr_a = wrap_inc(wptr_a);
    end
    cnt_a = cnt_a + int'(exp_enq) - int'(exp_deq);
    @(posedge clock); #1;
  endtask

  task automatic cycle_b(input logic ev, input logic [78:0] eb, input logic dr);
    logic exp_bypass, exp_enq, exp_dv, exp_deq;
    logic [78:0] exp_bits;
    ifb.io_enq_valid = ev; ifb.io_enq_bits = eb; ifb.io_deq_ready = dr;
    @(negedge clock);
    exp_bypass = (cnt_b == 0) && ev && dr;
    exp_enq    = ev && (cnt_b < 5) && !exp_bypass;
    exp_dv     = (cnt_b > 0) || ev;
    exp_deq    = dr && exp_dv;
    check_eq("b_enq_ready", ifb.io_enq_ready, cnt_b < 5);
    check_eq("b_deq_valid", ifb.io_deq_valid, exp_dv);
    check_eq("b_count",     ifb.io_count,     cnt_b);
    check_eq("b_w_en",      ifb.mem_W0_en,    exp_enq);
    if (exp_enq) check_eq("b_w_addr", ifb.mem_W0_addr, wptr_b);
    if (cnt_b == 0 && ev) check_eq("b_bypass_bits", ifb.io_deq_bits, eb);
    if (exp_deq && !exp_bypass) begin
      exp_bits = sb_b.pop_front();
      check_eq("b_deq_bits", ifb.io_deq_bits, exp_bits);
      rptr_b = wrap_inc(rptr_b);
    end
    if (exp_enq) begin
      sb_b.push_back(eb);
      wptr_b = wrap_inc(wptr_b);
    end
    cnt_b = cnt_b + int'(exp_enq) - int'(exp_deq && !exp_bypass);
    @(posedge clock); #1;
  endtask

  task automatic drain_a();
    for (int i = 0; i < 6; i++) cycle_a(1'b0, 79'd0, 1'b1);
  endtask

  initial begin
    ifa.io_enq_valid = 1'b0; ifa.io_enq_bits = '0; ifa.io_deq_ready = 1'b0;
    ifb.io_enq_valid = 1'b0; ifb.io_enq_bits = '0; ifb.io_deq_ready = 1'b0;
    @(posedge clock); #1;
    do_reset(2);
    cycle_a(1'b0, 79'd0, 1'b0);

    // fill with 1..5, then a rejected 6th, then drain; three rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= 5; i++) cycle_a(1'b1, 79'(r * 16 + i), 1'b0);
      cycle_a(1'b1, 79'h66, 1'b0);
      drain_a();
    end

    // simultaneous traffic holding at 3 entries
    for (int i = 0; i < 3; i++) cycle_a(1'b1, rand_word(), 1'b0);
    for (int i = 0; i < 10; i++) cycle_a(1'b1, rand_word(), 1'b1);
    drain_a();

    // full plus simultaneous: only dequeue, then enqueue next cycle
    for (int i = 0; i < 5; i++) cycle_a(1'b1, rand_word(), 1'b0);
    cycle_a(1'b1, 79'hAA, 1'b1);
    cycle_a(1'b1, 79'hAA, 1'b0);
    drain_a();

    // reset mid-run at 3 entries
    for (int i = 0; i < 3; i++) cycle_a(1'b1, rand_word(), 1'b0);
    do_reset(1);
    cycle_a(1'b0, 79'd0, 1'b0);
    cycle_a(1'b1, 79'h55, 1'b0);
    drain_a();

    // random traffic
    for (int i = 0; i < 200; i++)
      cycle_a(1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)));
    drain_a();

    // FLOW=1 instance: bypass, then write-instead, then random
    do_reset(1);
    cycle_b(1'b1, 79'h7FFF, 1'b1);
    cycle_b(1'b1, 79'h7FFF, 1'b0);
    cycle_b(1'b0, 79'd0, 1'b1);
    cycle_b(1'b0, 79'd0, 1'b0);
    for (int i = 0; i < 150; i++)
      cycle_b(1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++) cycle_b(1'b0, 79'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
